// File: rtl/key_pkg.sv
// key_pkg: definitions shared by the key event arbiter and the debounce
// detector bank wrapper.
//   state_t               - arbiter FSM state encoding
//   KEY_NUM_DEFAULT       - default number of key inputs
//   KEY_IDX_BITS_DEFAULT  - default key index width
package key_pkg;

  localparam int unsigned KEY_NUM_DEFAULT      = 4;
  localparam int unsigned KEY_IDX_BITS_DEFAULT = 2;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Returns the first set request bit searching upward from ptr, wrapping
// from NUM_KEYS-1 back to 0.
//   req [NUM_KEYS]  - request bitmap
//   ptr [IDX_BITS]  - search start index (expected < NUM_KEYS)
//   any             - at least one request set
//   idx [IDX_BITS]  - selected index (0 when any is low)
module rr_pick
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS = KEY_NUM_DEFAULT,
  parameter int unsigned IDX_BITS = KEY_IDX_BITS_DEFAULT
) (
  input  logic [NUM_KEYS-1:0] req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic                any,
  output logic [IDX_BITS-1:0] idx
);

  // One extra bit so ptr+offset cannot overflow before the wrap compare.
  logic [IDX_BITS:0] w_pos;

  always_comb begin
    any   = 1'b0;
    idx   = '0;
    w_pos = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      w_pos = {1'b0, ptr} + (IDX_BITS+1)'(i);
      // Explicit wrap so non-power-of-2 key counts work.
      if (w_pos >= (IDX_BITS+1)'(NUM_KEYS)) begin
        w_pos = w_pos - (IDX_BITS+1)'(NUM_KEYS);
      end
      if (!any && req[w_pos[IDX_BITS-1:0]]) begin
        any = 1'b1;
        idx = w_pos[IDX_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// key_event_arbiter: latches single-cycle key press pulses as pending events
// and presents them one at a time, round-robin, over a valid/ready handshake.
//   sys_clk      - clock, rising edge
//   sys_rst      - synchronous reset, active-high
//   key_pulse_i  - one-cycle press pulses, bit n = key n
//   evt_valid_o  - event presented on evt_code_o
//   evt_code_o   - index of presented key
//   evt_ready_i  - consumer accepts when high with evt_valid_o
//   pending_o    - pending-event bitmap
//   drop_o       - one-cycle pulse: press discarded because key already pending
module key_event_arbiter
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS = KEY_NUM_DEFAULT,
  parameter int unsigned IDX_BITS = KEY_IDX_BITS_DEFAULT
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_pulse_i,
  output logic                evt_valid_o,
  output logic [IDX_BITS-1:0] evt_code_o,
  input  logic                evt_ready_i,
  output logic [NUM_KEYS-1:0] pending_o,
  output logic                drop_o
);

  state_t              r_state, w_state_next;
  logic [NUM_KEYS-1:0] r_pending, w_pending_next, w_clear;
  logic                r_valid, w_valid_next;
  logic [IDX_BITS-1:0] r_code, w_code_next;
  logic [IDX_BITS-1:0] r_ptr, w_ptr_next;
  logic                r_drop, w_drop_next;
  logic                w_hs;
  logic                w_any;
  logic [IDX_BITS-1:0] w_pick;

  // Arbitrates over the registered bitmap only, so same-cycle pulses wait
  // for the next IDLE cycle.
  rr_pick #(
    .NUM_KEYS (NUM_KEYS),
    .IDX_BITS (IDX_BITS)
  ) u_rr_pick (
    .req (r_pending),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_pick)
  );

  assign w_hs    = r_valid & evt_ready_i;
  assign w_clear = w_hs ? (NUM_KEYS'(1) << r_code) : '0;

  always_comb begin
    w_state_next   = r_state;
    w_valid_next   = r_valid;
    w_code_next    = r_code;
    w_ptr_next     = r_ptr;
    // Set wins over clear: a pulse on the key being accepted re-arms it.
    w_pending_next = (r_pending & ~w_clear) | key_pulse_i;
    w_drop_next    = |(key_pulse_i & r_pending & ~w_clear);

    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_code_next  = w_pick;
          w_valid_next = 1'b1;
          w_state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (w_hs) begin
          w_valid_next = 1'b0;
          w_ptr_next   = (r_code == IDX_BITS'(NUM_KEYS - 1)) ? '0
                                                             : r_code + IDX_BITS'(1);
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_code    <= '0;
      r_ptr     <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_valid   <= w_valid_next;
      r_code    <= w_code_next;
      r_ptr     <= w_ptr_next;
      r_drop    <= w_drop_next;
    end
  end

  assign evt_valid_o = r_valid;
  assign evt_code_o  = r_code;
  assign pending_o   = r_pending;
  assign drop_o      = r_drop;

endmodule

// File: tb/tb_key_event_arbiter.sv
module tb_key_event_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned IB = 2;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic [N-1:0]  key_pulse_i = '0;
  logic          evt_ready_i = 1'b0;
  logic          evt_valid_o;
  logic [IB-1:0] evt_code_o;
  logic [N-1:0]  pending_o;
  logic          drop_o;

  int errors = 0;
  int checks = 0;

  // Behavioural reference: set of outstanding presses, the event currently
  // offered, and the key after the last one served.
  bit          m_pend [N];
  bit          m_valid;
  int unsigned m_code;
  int unsigned m_next;
  bit          m_drop;

  always #5 sys_clk = ~sys_clk;

  key_event_arbiter #(
    .NUM_KEYS (N),
    .IDX_BITS (IB)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_pulse_i (key_pulse_i),
    .evt_valid_o (evt_valid_o),
    .evt_code_o  (evt_code_o),
    .evt_ready_i (evt_ready_i),
    .pending_o   (pending_o),
    .drop_o      (drop_o)
  );

  function automatic logic [N-1:0] m_pend_vec();
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k] = m_pend[k];
    return v;
  endfunction

  task automatic model_edge(input logic [N-1:0] p, input bit r, input bit rst);
    bit          accepted;
    bit          npend [N];
    bit          ndrop;
    bit          nvalid;
    int unsigned ncode, nnext;
    if (rst) begin
      for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
      m_valid = 0; m_code = 0; m_next = 0; m_drop = 0;
      return;
    end
    accepted = m_valid && r;
    ndrop    = 0;
    for (int k = 0; k < N; k++) begin
      bit taken;
      taken = accepted && (k == int'(m_code));
      if (p[k] && m_pend[k] && !taken) ndrop = 1;
      npend[k] = (m_pend[k] && !taken) || p[k];
    end
    nvalid = m_valid; ncode = m_code; nnext = m_next;
    if (!m_valid) begin
      for (int j = 0; j < N; j++) begin
        int unsigned c;
        c = (m_next + j) % N;
        if (!nvalid && m_pend[c]) begin
          nvalid = 1; ncode = c;
        end
      end
    end else if (accepted) begin
      nvalid = 0;
      nnext  = (m_code + 1) % N;
    end
    for (int k = 0; k < N; k++) m_pend[k] = npend[k];
    m_valid = nvalid; m_code = ncode; m_next = nnext; m_drop = ndrop;
  endtask

  // Drive for one cycle, advance the model on the same edge, sample 1ns later.
  task automatic step(input logic [N-1:0] p, input bit r, input bit rst);
    key_pulse_i = p;
    evt_ready_i = r;
    sys_rst     = rst;
    @(posedge sys_clk);
    model_edge(p, r, rst);
    #1;
    key_pulse_i = '0;
    sys_rst     = 1'b0;
  endtask

  task automatic test_reset();
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", evt_valid_o); end
    checks++; if (evt_code_o !== '0)    begin errors++; $display("FAIL reset_code got=%0d exp=0", evt_code_o); end
    checks++; if (pending_o !== '0)     begin errors++; $display("FAIL reset_pending got=%b exp=0000", pending_o); end
    checks++; if (drop_o !== 1'b0)      begin errors++; $display("FAIL reset_drop got=%b exp=0", drop_o); end
  endtask

  task automatic test_single_press();
    bit dropped;
    dropped = 0;
    for (int i = 0; i < 3; i++) step('0, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    dropped |= drop_o;
    checks++; if (pending_o !== 4'b0100 || evt_valid_o !== 1'b0) begin
      errors++; $display("FAIL single_t1 got pend=%b valid=%b exp pend=0100 valid=0", pending_o, evt_valid_o);
    end
    step('0, 1'b1, 1'b0);
    dropped |= drop_o;
    checks++; if (evt_valid_o !== 1'b1 || evt_code_o !== 2'd2) begin
      errors++; $display("FAIL single_t2 got valid=%b code=%0d exp valid=1 code=2", evt_valid_o, evt_code_o);
    end
    step('0, 1'b1, 1'b0);
    dropped |= drop_o;
    checks++; if (evt_valid_o !== 1'b0 || pending_o !== 4'b0000) begin
      errors++; $display("FAIL single_done got valid=%b pend=%b exp valid=0 pend=0000", evt_valid_o, pending_o);
    end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL single_nodrop got=1 exp=0"); end
  endtask

  task automatic test_simultaneous();
    int unsigned got[$];
    step('0, 1'b0, 1'b1);
    step(4'b1011, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step('0, 1'b1, 1'b0);
      if (evt_valid_o === 1'b1) got.push_back(int'(evt_code_o));
    end
    checks++; if (got.size() != 3) begin
      errors++; $display("FAIL simul_count got=%0d exp=3", got.size());
    end else begin
      checks++; if (got[0] != 0 || got[1] != 1 || got[2] != 3) begin
        errors++; $display("FAIL simul_order got=%0d,%0d,%0d exp=0,1,3", got[0], got[1], got[2]);
      end
    end
    step(4'b0001, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    checks++; if (evt_valid_o !== 1'b1 || evt_code_o !== 2'd0) begin
      errors++; $display("FAIL simul_wrap got valid=%b code=%0d exp valid=1 code=0", evt_valid_o, evt_code_o);
    end
    step('0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    bit stable;
    step('0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      step((i == 5) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
      if (evt_valid_o !== 1'b1 || evt_code_o !== 2'd1) stable = 0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL bp_stable got valid=%b code=%0d exp valid=1 code=1", evt_valid_o, evt_code_o); end
    checks++; if (pending_o !== 4'b1010) begin errors++; $display("FAIL bp_pending got=%b exp=1010", pending_o); end
    step('0, 1'b1, 1'b0);
    checks++; if (evt_valid_o !== 1'b0 || pending_o !== 4'b1000) begin
      errors++; $display("FAIL bp_accept1 got valid=%b pend=%b exp valid=0 pend=1000", evt_valid_o, pending_o);
    end
    step('0, 1'b1, 1'b0);
    checks++; if (evt_valid_o !== 1'b1 || evt_code_o !== 2'd3) begin
      errors++; $display("FAIL bp_second got valid=%b code=%0d exp valid=1 code=3", evt_valid_o, evt_code_o);
    end
    step('0, 1'b1, 1'b0);
  endtask

  task automatic test_drop();
    step('0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    checks++; if (pending_o !== 4'b0011 || drop_o !== 1'b0) begin
      errors++; $display("FAIL drop_setup got pend=%b drop=%b exp pend=0011 drop=0", pending_o, drop_o);
    end
    step(4'b0001, 1'b0, 1'b0);
    checks++; if (drop_o !== 1'b1 || pending_o !== 4'b0011) begin
      errors++; $display("FAIL drop_pulse got drop=%b pend=%b exp drop=1 pend=0011", drop_o, pending_o);
    end
    step('0, 1'b0, 1'b0);
    checks++; if (drop_o !== 1'b0) begin errors++; $display("FAIL drop_single got=%b exp=0", drop_o); end
    // Re-press key 1 in its own acceptance cycle.
    step(4'b0010, 1'b1, 1'b0);
    checks++; if (drop_o !== 1'b0 || pending_o !== 4'b0011 || evt_valid_o !== 1'b0) begin
      errors++; $display("FAIL drop_rearm got drop=%b pend=%b valid=%b exp drop=0 pend=0011 valid=0", drop_o, pending_o, evt_valid_o);
    end
    step('0, 1'b1, 1'b0);
    checks++; if (evt_valid_o !== 1'b1 || evt_code_o !== 2'd0) begin
      errors++; $display("FAIL drop_next got valid=%b code=%0d exp valid=1 code=0", evt_valid_o, evt_code_o);
    end
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    checks++; if (evt_valid_o !== 1'b1 || evt_code_o !== 2'd1) begin
      errors++; $display("FAIL drop_again got valid=%b code=%0d exp valid=1 code=1", evt_valid_o, evt_code_o);
    end
    step('0, 1'b1, 1'b0);
  endtask

  task automatic test_fairness();
    int events, first2;
    logic [N-1:0] p;
    step('0, 1'b0, 1'b1);
    step(4'b0111, 1'b1, 1'b0);
    events = 0;
    first2 = -1;
    for (int cyc = 0; cyc < 200 && events < 50; cyc++) begin
      p = (m_valid && m_code < 2) ? (N'(1) << m_code) : '0;
      step(p, 1'b1, 1'b0);
      if (evt_valid_o === 1'b1) begin
        if (evt_code_o === 2'd2 && first2 < 0) first2 = events;
        events++;
      end
    end
    checks++; if (events < 50) begin errors++; $display("FAIL fair_budget got=%0d exp=50", events); end
    checks++; if (first2 < 0 || first2 > 2) begin
      errors++; $display("FAIL fair_key2 got position=%0d exp 0..2", first2);
    end
    for (int i = 0; i < 4; i++) step('0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    step('0, 1'b0, 1'b1);
    step(4'b0110, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    checks++; if (evt_valid_o !== 1'b1 || pending_o !== 4'b0110) begin
      errors++; $display("FAIL rmid_setup got valid=%b pend=%b exp valid=1 pend=0110", evt_valid_o, pending_o);
    end
    step('0, 1'b0, 1'b1);
    checks++; if (evt_valid_o !== 1'b0 || pending_o !== 4'b0000 || drop_o !== 1'b0) begin
      errors++; $display("FAIL rmid_clear got valid=%b pend=%b drop=%b exp 0/0000/0", evt_valid_o, pending_o, drop_o);
    end
    step(4'b1000, 1'b1, 1'b0);
    checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_lat1 got valid=%b exp=0", evt_valid_o); end
    step('0, 1'b1, 1'b0);
    checks++; if (evt_valid_o !== 1'b1 || evt_code_o !== 2'd3) begin
      errors++; $display("FAIL rmid_press got valid=%b code=%0d exp valid=1 code=3", evt_valid_o, evt_code_o);
    end
    step('0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] p;
    bit r, rst;
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      p   = N'($urandom) & N'($urandom) & N'($urandom);
      r   = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 149) == 0);
      step(p, r, rst);
      checks++; if (evt_valid_o !== m_valid || (m_valid && evt_code_o !== IB'(m_code))) begin
        errors++; $display("FAIL rnd_event cyc=%0d got valid=%b code=%0d exp valid=%b code=%0d", i, evt_valid_o, evt_code_o, m_valid, m_code);
      end
      checks++; if (pending_o !== m_pend_vec()) begin
        errors++; $display("FAIL rnd_pending cyc=%0d got=%b exp=%b", i, pending_o, m_pend_vec());
      end
      checks++; if (drop_o !== m_drop) begin
        errors++; $display("FAIL rnd_drop cyc=%0d got=%b exp=%b", i, drop_o, m_drop);
      end
    end
  endtask

  initial begin
    model_edge('0, 1'b0, 1'b1);
    test_reset();
    test_single_press();
    test_simultaneous();
    test_backpressure();
    test_drop();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
